// File: rtl/lsu_controller.sv
// Load/store sequencer: aligns core accesses onto a word-addressed req/gnt/rvalid
// memory, splitting misaligned halfword/word accesses into two aligned beats.
module lsu_controller #(
  parameter bit SUPPORT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t      state, state_next;
  logic        we_r, err_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r, wdata_r, rdata0_r, rdata1_r;

  logic        req_bad, second_beat;
  logic [7:0]  m8;
  logic [63:0] wlanes;
  logic [31:0] merged, beat0_addr, beat1_addr;

  function automatic logic [3:0] width_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   width_mask = 4'b0001;
      2'b01:   width_mask = 4'b0011;
      default: width_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    illegal_f3 = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    misaligned = ((sz == 2'b01) && (off == 2'd3)) || ((sz == 2'b10) && (off != 2'd0));
  endfunction

  // Keep only the accessed bytes, then sign- or zero-extend on f3[2].
  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [31:0] val);
    logic signed [31:0] res;
    case (f3[1:0])
      2'b00:   res = f3[2] ? {24'b0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
      2'b01:   res = f3[2] ? {16'b0, val[15:0]} : {{16{val[15]}}, val[15:0]};
      default: res = val;
    endcase
    format_load = res;
  endfunction

  assign req_bad     = illegal_f3(req_we, req_f3) ||
                       (!SUPPORT_MISALIGNED && misaligned(req_f3[1:0], req_addr[1:0]));
  assign m8          = 8'(width_mask(f3_r[1:0])) << addr_r[1:0];
  assign second_beat = |m8[7:4];
  assign wlanes      = {32'b0, wdata_r} << {addr_r[1:0], 3'b000};
  assign merged      = 32'({rdata1_r, rdata0_r} >> {addr_r[1:0], 3'b000});
  assign beat0_addr  = {addr_r[31:2], 2'b00};
  assign beat1_addr  = beat0_addr + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_bad ? RESP : REQ0;
      REQ0:    if (mem_gnt) state_next = WAIT0;
      WAIT0:   if (mem_rvalid) state_next = second_beat ? REQ1 : RESP;
      REQ1:    if (mem_gnt) state_next = WAIT1;
      WAIT1:   if (mem_rvalid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields and beat data carry no reset; they are only consumed after acceptance.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      we_r    <= req_we;
      f3_r    <= req_f3;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      err_r   <= req_bad;
    end
    if (state == WAIT0 && mem_rvalid) rdata0_r <= mem_rdata;
    if (state == WAIT1 && mem_rvalid) rdata1_r <= mem_rdata;
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 32'b0;
    mem_be     = 4'b0;
    mem_wdata  = 32'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      REQ0: begin
        mem_req   = 1'b1;
        mem_we    = we_r;
        mem_addr  = beat0_addr;
        mem_be    = m8[3:0];
        mem_wdata = wlanes[31:0];
      end
      REQ1: begin
        mem_req   = 1'b1;
        mem_we    = we_r;
        mem_addr  = beat1_addr;
        mem_be    = m8[7:4];
        mem_wdata = wlanes[63:32];
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_r;
        resp_rdata = (err_r || we_r) ? 32'b0 : format_load(f3_r, merged);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller: aligned/split transfers, grant stall,
// error responses and mid-transaction reset, against hand-computed vectors.
module tb_lsu_controller;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        req_valid_b, req_ready_b, req_we_b;
  logic [2:0]  req_f3_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic        resp_valid_b, resp_err_b;
  logic [31:0] resp_rdata_b;
  logic        mem_req_b, mem_gnt_b, mem_we_b, mem_rvalid_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [3:0]  mem_be_b;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int overlap = 0;

  lsu_controller #(.SUPPORT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_f3(req_f3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_controller #(.SUPPORT_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b), .req_f3(req_f3_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .mem_req(mem_req_b), .mem_gnt(mem_gnt_b), .mem_addr(mem_addr_b), .mem_we(mem_we_b),
    .mem_be(mem_be_b), .mem_wdata(mem_wdata_b), .mem_rvalid(mem_rvalid_b), .mem_rdata(mem_rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resp_valid) pulses++;
    if (resp_valid && req_ready) overlap++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_rdata}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b rv=%b err=%b req=%b we=%b be=%h addr=%h wd=%h rd=%h, want rdy=1 others 0",
               req_ready, resp_valid, resp_err, mem_req, mem_we, mem_be, mem_addr, mem_wdata, resp_rdata);
    end
    vectors++;
    if ({req_ready_b, resp_valid_b, mem_req_b, mem_be_b} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
      miscompares++;
      $display("FAIL reset_b: got rdy=%b rv=%b req=%b be=%h, want 1 0 0 0",
               req_ready_b, resp_valid_b, mem_req_b, mem_be_b);
    end
    rst = 1'b0;
    step();
  endtask

  // Drives one transfer with grant in the request cycle and rvalid one cycle later.
  task automatic run_xfer(input string name, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] d0, input logic [31:0] d1, input logic split,
                          input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] w0,
                          input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] w1,
                          input logic [31:0] exp_rdata);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, req_ready} !== {1'b1, we, a0, be0, w0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s beat0: got req=%b we=%b addr=%h be=%b wd=%h rdy=%b want 1 %b %h %b %h 0",
               name, mem_req, mem_we, mem_addr, mem_be, mem_wdata, req_ready, we, a0, be0, w0);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = d0;
    step();
    mem_rvalid = 1'b0;
    if (split) begin
      vectors++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, we, a1, be1, w1}) begin
        miscompares++;
        $display("FAIL %s beat1: got req=%b we=%b addr=%h be=%b wd=%h want 1 %b %h %b %h",
                 name, mem_req, mem_we, mem_addr, mem_be, mem_wdata, we, a1, be1, w1);
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = d1;
      step();
      mem_rvalid = 1'b0;
    end
    vectors++;
    if ({resp_valid, resp_err, resp_rdata, req_ready, mem_req} !== {1'b1, 1'b0, exp_rdata, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s resp: got rv=%b err=%b rd=%h rdy=%b req=%b want 1 0 %h 0 0",
               name, resp_valid, resp_err, resp_rdata, req_ready, mem_req, exp_rdata);
    end
    step();
    vectors++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s after_resp: got rv=%b rdy=%b want 0 1", name, resp_valid, req_ready);
    end
  endtask

  task automatic test_aligned_load();
    run_xfer("lw_100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0,
             32'h100, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF);
    run_xfer("lb_203", 1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 32'h0, 1'b0,
             32'h200, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80);
    run_xfer("lbu_203", 1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 32'h0, 1'b0,
             32'h200, 4'b1000, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00000080);
    run_xfer("lh_202", 1'b0, 3'b001, 32'h202, 32'h0, 32'h80112233, 32'h0, 1'b0,
             32'h200, 4'b1100, 32'h0, 32'h0, 4'h0, 32'h0, 32'hFFFF8011);
    run_xfer("lhu_201", 1'b0, 3'b101, 32'h201, 32'h0, 32'h80112233, 32'h0, 1'b0,
             32'h200, 4'b0110, 32'h0, 32'h0, 4'h0, 32'h0, 32'h00001122);
  endtask

  task automatic test_store();
    run_xfer("sh_12", 1'b1, 3'b001, 32'h12, 32'h0000ABCD, 32'hFFFFFFFF, 32'h0, 1'b0,
             32'h10, 4'b1100, 32'hABCD0000, 32'h0, 4'h0, 32'h0, 32'h0);
    run_xfer("sb_7", 1'b1, 3'b000, 32'h7, 32'h123456EE, 32'hFFFFFFFF, 32'h0, 1'b0,
             32'h4, 4'b1000, 32'hEE000000, 32'h0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic test_misaligned();
    run_xfer("lw_101", 1'b0, 3'b010, 32'h101, 32'h0, 32'h44332211, 32'h88776655, 1'b1,
             32'h100, 4'b1110, 32'h0, 32'h104, 4'b0001, 32'h0, 32'h55443322);
    run_xfer("sw_3", 1'b1, 3'b010, 32'h3, 32'hAABBCCDD, 32'h0, 32'h0, 1'b1,
             32'h0, 4'b1000, 32'hDD000000, 32'h4, 4'b0111, 32'h00AABBCC, 32'h0);
    run_xfer("lh_wrap", 1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hAB000000, 32'h000000CD, 1'b1,
             32'hFFFFFFFC, 4'b1000, 32'h0, 32'h0, 4'b0001, 32'h0, 32'hFFFFCDAB);
  endtask

  task automatic test_grant_delay();
    int p0;
    p0 = pulses;
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h12345678;
    step();
    req_valid = 1'b0; req_wdata = 32'h0; req_addr = 32'h0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) mem_gnt = 1'b1;
      vectors++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, req_ready, resp_valid}
          !== {1'b1, 1'b1, 32'h8, 4'b1111, 32'h12345678, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL gnt_hold[%0d]: got req=%b we=%b addr=%h be=%b wd=%h rdy=%b rv=%b want 1 1 8 1111 12345678 0 0",
                 c, mem_req, mem_we, mem_addr, mem_be, mem_wdata, req_ready, resp_valid);
      end
      step();
    end
    mem_gnt = 1'b0;
    step();
    vectors++;
    if ({mem_req, req_ready, resp_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL gnt_wait: got req=%b rdy=%b rv=%b want 0 0 0", mem_req, req_ready, resp_valid);
    end
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    step();
    step();
    vectors++;
    if (pulses - p0 != 1) begin
      miscompares++;
      $display("FAIL gnt_pulses: got %0d want 1", pulses - p0);
    end
  endtask

  task automatic test_errors();
    req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b011; req_addr = 32'h40;
    step();
    req_valid = 1'b0;
    vectors++;
    if ({resp_valid, resp_err, resp_rdata, mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL err_f3_011: got rv=%b err=%b rd=%h req=%b want 1 1 0 0",
               resp_valid, resp_err, resp_rdata, mem_req);
    end
    step();
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b100; req_addr = 32'h40; req_wdata = 32'hFF;
    step();
    req_valid = 1'b0;
    vectors++;
    if ({resp_valid, resp_err, mem_req} !== 3'b110) begin
      miscompares++;
      $display("FAIL err_store_u: got rv=%b err=%b req=%b want 1 1 0", resp_valid, resp_err, mem_req);
    end
    step();
    req_valid_b = 1'b1; req_we_b = 1'b0; req_f3_b = 3'b001; req_addr_b = 32'h3;
    step();
    req_valid_b = 1'b0;
    vectors++;
    if ({resp_valid_b, resp_err_b, resp_rdata_b, mem_req_b} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL err_misal_b: got rv=%b err=%b rd=%h req=%b want 1 1 0 0",
               resp_valid_b, resp_err_b, resp_rdata_b, mem_req_b);
    end
    step();
    req_valid_b = 1'b1; req_f3_b = 3'b000; req_addr_b = 32'h3;
    step();
    req_valid_b = 1'b0;
    vectors++;
    if ({mem_req_b, mem_be_b, resp_valid_b} !== {1'b1, 4'b1000, 1'b0}) begin
      miscompares++;
      $display("FAIL lb_ok_b: got req=%b be=%b rv=%b want 1 1000 0", mem_req_b, mem_be_b, resp_valid_b);
    end
    mem_gnt_b = 1'b1;
    step();
    mem_gnt_b = 1'b0; mem_rvalid_b = 1'b1; mem_rdata_b = 32'h7F000000;
    step();
    mem_rvalid_b = 1'b0;
    vectors++;
    if ({resp_valid_b, resp_err_b, resp_rdata_b} !== {1'b1, 1'b0, 32'h0000007F}) begin
      miscompares++;
      $display("FAIL lb_resp_b: got rv=%b err=%b rd=%h want 1 0 0000007f", resp_valid_b, resp_err_b, resp_rdata_b);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pulses;
    req_valid = 1'b1; req_we = 1'b0; req_f3 = 3'b010; req_addr = 32'h100;
    step();
    req_valid = 1'b0; mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({req_ready, resp_valid, mem_req, mem_addr, mem_be} !== {1'b1, 1'b0, 1'b0, 32'h0, 4'h0}) begin
      miscompares++;
      $display("FAIL rst_mid: got rdy=%b rv=%b req=%b addr=%h be=%b want 1 0 0 0 0",
               req_ready, resp_valid, mem_req, mem_addr, mem_be);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF; mem_gnt = 1'b1;
    step();
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    step();
    vectors++;
    if ({req_ready, resp_valid, mem_req} !== 3'b100 || pulses != p0) begin
      miscompares++;
      $display("FAIL stray_rvalid: got rdy=%b rv=%b req=%b pulses=%0d want 1 0 0 pulses=0",
               req_ready, resp_valid, mem_req, pulses - p0);
    end
    run_xfer("lw_recover", 1'b0, 3'b010, 32'h200, 32'h0, 32'h0BADF00D, 32'h0, 1'b0,
             32'h200, 4'b1111, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0BADF00D);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_f3_b = 3'b0; req_addr_b = 32'h0; req_wdata_b = 32'h0;
    mem_gnt_b = 1'b0; mem_rvalid_b = 1'b0; mem_rdata_b = 32'h0;
    #1;
    test_reset();
    test_aligned_load();
    test_store();
    test_misaligned();
    test_grant_delay();
    test_errors();
    test_reset_mid();
    vectors++;
    if (overlap != 0) begin
      miscompares++;
      $display("FAIL ready_resp_overlap: got %0d cycles want 0", overlap);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_controller.md
Name: lsu_controller

Overview:
- Load/store sequencer between the core's memory stage and a single-port, word-addressed data memory with a req/gnt/rvalid handshake.
- Generates word-aligned addresses and byte-enable masks, and positions store data on the correct byte lanes.
- Splits misaligned halfword/word accesses into two aligned beats, merges the returned load bytes, and sign/zero-extends per f3.
- The core stalls on req_ready / resp_valid.

Parameters:
- SUPPORT_MISALIGNED, 1: 1 = split misaligned accesses into two beats; 0 = respond with resp_err and issue no memory access.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller idle and can accept a request
- req_we  in  1  1 = store, 0 = load
- req_f3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  formatted load data; 0 for stores and errors
- resp_err  out  1  illegal f3, or misaligned with SUPPORT_MISALIGNED=0; valid with resp_valid
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepts request this cycle
- mem_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_we  out  1  write enable
- mem_be  out  4  byte-enable mask
- mem_wdata  out  32  lane-positioned write data
- mem_rvalid  in  1  read data or write acknowledge, at least 1 cycle after grant
- mem_rdata  in  32  read data

Behaviour:
- Reset: state IDLE. req_ready=1; resp_valid, resp_err, mem_req, mem_we = 0; mem_be=0; mem_addr, mem_wdata, resp_rdata = 0.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch we/f3/addr/wdata and set off=addr[1:0].
  - Illegal f3 (011, 110, 111, or store with f3[2]=1): go to RESP with err=1.
  - Misaligned access (H with off=3, W with off!=0) and SUPPORT_MISALIGNED=0: go to RESP with err=1.
  - Otherwise go to REQ0.
- Masks and beat count:
  - Width mask: B=0001, H=0011, W=1111.
  - Full mask: m8 = widthmask << off (8 bits).
  - Beat0 uses be=m8[3:0]. Beat1 uses be=m8[7:4] and is issued only if m8[7:4]!=0.
- REQ0: mem_req=1, mem_addr={addr[31:2],2'b00}, be=m8[3:0], mem_wdata=wdata<<(8*off). Hold all outputs stable until mem_gnt, then go to WAIT0.
- WAIT0: on mem_rvalid, capture rdata0. Go to REQ1 if a second beat is needed, else RESP.
- REQ1: mem_addr = beat0 address + 4 (wraps modulo 2^32), be=m8[7:4], mem_wdata=wdata>>(8*(4-off)). On mem_gnt go to WAIT1.
- WAIT1: on mem_rvalid, capture rdata1, go to RESP.
- Load data assembly:
  - Merged 64-bit value = {rdata1, rdata0} >> (8*off), low 32 bits kept.
  - Bytes outside the mask are zeroed before extension.
  - B/H are sign-extended when f3[2]=0, zero-extended when f3[2]=1. W passes through.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE.
- Latency with grant in the same cycle as mem_req and rvalid 1 cycle after grant:
  - Aligned access: accepted at cycle 0, resp_valid at cycle 3.
  - Split access: resp_valid at cycle 5.
  - Error response: resp_valid at cycle 1.
- mem_rvalid outside WAIT0/WAIT1 is ignored. mem_gnt outside REQ0/REQ1 is ignored.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. No response is issued for the aborted request. A later stray mem_rvalid is ignored.
- Only one transaction is outstanding at a time. resp_valid and req_ready are never both 1 in the same cycle.

Test Plan:
- Aligned LW addr 0x100, mem returns 0xDEADBEEF -> one beat, mem_addr=0x100, be=1111; resp_rdata=0xDEADBEEF at cycle 3, resp_err=0.
- LB addr 0x203, mem_rdata=0x80112233 -> be=1000; resp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x12, wdata=0x0000ABCD -> mem_addr=0x10, be=1100, mem_wdata=0xABCD0000, mem_we=1; resp_valid after ack, resp_rdata=0.
- Misaligned LW addr 0x101, beat0 data 0x44332211, beat1 data 0x88776655:
  - Beat0: mem_addr=0x100, be=1110. Beat1: mem_addr=0x104, be=0001.
  - resp_rdata=0x55443322 at cycle 5.
- Grant delayed 3 cycles on SW addr 0x8, wdata=0x12345678 -> mem_req, mem_addr, mem_be and mem_wdata held stable throughout; req_ready=0; exactly one resp_valid pulse.
- f3=011 load -> resp_err=1 at cycle 1, no mem_req. With SUPPORT_MISALIGNED=0, LH addr 0x3 -> resp_err=1, no mem_req. rst asserted in WAIT0 -> IDLE next cycle, no resp_valid, and a following stray mem_rvalid is ignored.
